// File: rtl/mem_arbiter_pkg.sv
// Shared constants and state encoding for the memory arbiter and its fill counter.
package mem_arbiter_pkg;

    localparam int unsigned MEM_LAT     = 4;
    localparam int unsigned BLOCK_WORDS = 8;
    localparam int unsigned WORD_IDX_W  = $clog2(BLOCK_WORDS);

    typedef enum logic [1:0] {
        StIdle,
        StIfill,
        StDfill,
        StWrite
    } arb_state_e;

endpackage

// File: rtl/mem_arbiter_fill_counter.sv
// Issue/return counter pair for one block fill; both counters clear whenever the fill is inactive.
module mem_arbiter_fill_counter
    import mem_arbiter_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  active,
    input  logic                  mem_valid,
    output logic                  issue_en,
    output logic [WORD_IDX_W-1:0] issue_idx,
    output logic [WORD_IDX_W-1:0] ret_idx,
    output logic                  last_ret
);

    localparam logic [WORD_IDX_W:0]   IssueOne = 1;
    localparam logic [WORD_IDX_W-1:0] RetOne   = 1;
    localparam logic [WORD_IDX_W-1:0] RetLast  = WORD_IDX_W'(BLOCK_WORDS - 1);

    // Extra MSB on the issue counter marks "all words issued".
    logic [WORD_IDX_W:0]   issue_q;
    logic [WORD_IDX_W-1:0] ret_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            issue_q <= '0;
            ret_q   <= '0;
        end else if (!active) begin
            issue_q <= '0;
            ret_q   <= '0;
        end else begin
            if (!issue_q[WORD_IDX_W]) begin
                issue_q <= issue_q + IssueOne;
            end
            if (mem_valid && (ret_q != RetLast)) begin
                ret_q <= ret_q + RetOne;
            end
        end
    end

    assign issue_en  = active && !issue_q[WORD_IDX_W];
    assign issue_idx = issue_q[WORD_IDX_W-1:0];
    assign ret_idx   = ret_q;
    assign last_ret  = active && mem_valid && (ret_q == RetLast);

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the single-ported pipelined memory between I-cache fills and D-cache fills/writes.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_req,
    input  logic [ADDR_W-1:0]     i_addr,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [ADDR_W-1:0]     d_addr,
    input  logic [DATA_W-1:0]     d_wdata,
    output logic                  i_gnt,
    output logic                  d_gnt,
    output logic                  i_valid,
    output logic                  d_valid,
    output logic [DATA_W-1:0]     fill_data,
    output logic [WORD_IDX_W-1:0] fill_word,
    output logic                  i_done,
    output logic                  d_done,
    output logic                  mem_en,
    output logic                  mem_wr,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    input  logic [DATA_W-1:0]     mem_rdata,
    input  logic                  mem_valid,
    output logic                  busy
);

    localparam int unsigned OFF_W = WORD_IDX_W + 1;

    arb_state_e            state;
    logic [ADDR_W-1:0]     addr_q;
    logic [DATA_W-1:0]     wdata_q;
    logic                  fill_active;
    logic                  issue_en;
    logic                  last_ret;
    logic [WORD_IDX_W-1:0] issue_idx;
    logic [WORD_IDX_W-1:0] ret_idx;
    logic [ADDR_W-1:0]     block_base;
    logic [ADDR_W-1:0]     write_addr;
    logic                  fwd;
    logic                  unused_addr_lsb;

    assign fill_active     = (state == StIfill) || (state == StDfill);
    assign block_base      = {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
    assign write_addr      = {addr_q[ADDR_W-1:1], 1'b0};
    assign unused_addr_lsb = addr_q[0];

    // Raw request address is latched; block/word alignment is applied on use.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= StIdle;
            i_gnt   <= 1'b0;
            d_gnt   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (d_req) begin
                        addr_q  <= d_addr;
                        wdata_q <= d_wdata;
                        d_gnt   <= 1'b1;
                        state   <= d_we ? StWrite : StDfill;
                    end else if (i_req) begin
                        addr_q <= i_addr;
                        i_gnt  <= 1'b1;
                        state  <= StIfill;
                    end
                end
                StIfill: begin
                    if (last_ret) begin
                        i_gnt <= 1'b0;
                        state <= StIdle;
                    end
                end
                StDfill: begin
                    if (last_ret) begin
                        d_gnt <= 1'b0;
                        state <= StIdle;
                    end
                end
                StWrite: begin
                    d_gnt <= 1'b0;
                    state <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

    mem_arbiter_fill_counter u_fill_counter (
        .clk       (clk),
        .rst       (rst),
        .active    (fill_active),
        .mem_valid (mem_valid),
        .issue_en  (issue_en),
        .issue_idx (issue_idx),
        .ret_idx   (ret_idx),
        .last_ret  (last_ret)
    );

    always_comb begin
        mem_en    = 1'b0;
        mem_wr    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (issue_en) begin
            mem_en   = 1'b1;
            mem_addr = block_base + ADDR_W'({issue_idx, 1'b0});
        end
        if (state == StWrite) begin
            mem_en    = 1'b1;
            mem_wr    = 1'b1;
            mem_addr  = write_addr;
            mem_wdata = wdata_q;
        end
    end

    // Returns outside a fill are dropped, and data is zeroed when nothing is forwarded.
    always_comb begin
        fwd       = fill_active && mem_valid;
        i_valid   = (state == StIfill) && mem_valid;
        d_valid   = (state == StDfill) && mem_valid;
        fill_data = fwd ? mem_rdata : '0;
        fill_word = fwd ? ret_idx : '0;
        i_done    = (state == StIfill) && last_ret;
        d_done    = ((state == StDfill) && last_ret) || (state == StWrite);
        busy      = (state != StIdle);
    end

endmodule
